auc_alu_arb: RTL and testbench
==============================

// Module: auc_alu_arb
// PURPOSE
//  Shares the single modular ALU and the operand RAM port between NREQ sequencers
//  (point-multiply engine, modular inverter, host loader).
//  Grants are round-robin and session-locked: the owner keeps the ALU/RAM port until
//  it drops its request and its last ALU op has returned.
//  Sits between the requester FSMs and the ALU/RAM, replacing ad-hoc output muxing.
// PARAMETERS
//  NREQ   3    number of requesters (2..8)
//  WID    256  ALU / RAM data width
//  AWID   5    RAM address width
//  OPWID  4    ALU opcode width
// PORTS
//  clk        in   1           clock
//  rst        in   1           reset; asynchronous, active-low
//  req        in   NREQ        session request, level; bit i = requester i
//  req_opcode in   NREQ*OPWID  per-requester ALU opcode, slice i = [i*OPWID +: OPWID]
//  req_auen   in   NREQ        per-requester ALU issue strobe
//  req_carry  in   NREQ        per-requester carry-in (sub)
//  req_swapop in   NREQ        per-requester swap operation
//  req_swapvl in   NREQ        per-requester swap value
//  req_ra     in   NREQ*AWID   per-requester RAM read address
//  req_wa     in   NREQ*AWID   per-requester RAM write address
//  req_we     in   NREQ        per-requester RAM write enable
//  req_wd     in   NREQ*WID    per-requester RAM write data
//  gnt        out  NREQ        one-hot grant, registered
//  req_auvld  out  NREQ        ALU result valid, routed to the owner only
//  alu_opcode out  OPWID       to ALU
//  alu_auen   out  1           to ALU
//  alu_carry  out  1           to ALU
//  alu_swapop out  1           to ALU
//  alu_swapvl out  1           to ALU
//  alu_auvld  in   1           ALU result valid
//  ram_ra     out  AWID        to RAM
//  ram_wa     out  AWID        to RAM
//  ram_we     out  1           to RAM
//  ram_wd     out  WID         to RAM
//  busy       out  1           ALU op outstanding
//  err        out  1           sticky protocol error; cleared only by rst
// BEHAVIOUR
//  Reset values: gnt=0, busy=0, err=0, state=IDLE, rr pointer=0.
//   All alu_*/ram_* outputs are 0 while no grant is held.
//  FSM:
//   IDLE  -> GRANT  when req!=0. Winner = first set bit at or after ptr, wrapping.
//                   gnt is registered, so it asserts on the edge after req is seen.
//                   ptr <= winner+1, wrapping NREQ-1 -> 0.
//   GRANT -> IDLE   when req[owner]=0 and busy=0.
//   GRANT -> DRAIN  when req[owner]=0 and busy=1 (or an auen is issued that cycle).
//   DRAIN -> IDLE   when alu_auvld=1.
//   There is no IDLE bubble skip: one dead cycle always separates two sessions.
//  Output muxing:
//   alu_*/ram_* are driven combinationally from the owner's slice in GRANT.
//   In DRAIN, auen and we are forced to 0; other fields stay muxed.
//  Owner is gnt's index.
//  Return routing: req_auvld[i] = alu_auvld & gnt[i]. gnt stays held through DRAIN.
//   alu result data is wired outside this block, owner-qualified by req_auvld.
//  busy set on a forwarded alu_auen; cleared on alu_auvld.
//   auen and auvld in the same cycle while busy: busy stays 1 (new op).
//  err set on any of:
//   - forwarded auen while busy and no auvld that cycle (op dropped, not forwarded)
//   - alu_auvld while busy=0
//   - req_auen/req_we from a non-owner
//  Non-owner strobes are always masked; they never reach the ALU/RAM.
//  An owner that drops req in the same cycle as auen: the op is forwarded, then DRAIN.
//  Requests from other requesters wait; there is no preemption.
//  rst mid-session: immediate return to reset values. An in-flight ALU result is ignored.
//  Latency: req to gnt = 1 cycle; owner strobe to ALU = 0 cycles (combinational).
// STRUCTURE
//  auc_pkg: width constants WID/AWID/OPWID and state encodings IDLE/GRANT/DRAIN.
//  Sub-module auc_rrpick: combinational round-robin first-one finder.
//   Inputs req, ptr; outputs one-hot win and its index.
//   Width-parameterised and reused by later arbiters.
// TESTING
//  1 Single requester: req=001, auen with opcode=4'h3, auvld 5 cycles later, then drop req
//    -> gnt=001 at cycle 1; alu_opcode=3; req_auvld=001 once; gnt=000 after.
//  2 Round-robin: req=111 held, each owner drops req after 1 op
//    -> grant order 0,1,2,0; exactly one idle cycle between sessions.
//  3 Drain: owner 1 drops req in the same cycle as auen, auvld 8 cycles later
//    -> gnt=010 held 8 cycles; req 2 granted only on the edge after auvld+1.
//  4 Masking: requester 2 pulses we with wd=all-ones while 0 owns
//    -> ram_we stays at owner 0's value; err=1 and stays 1.
//  5 Back-to-back: second auen while busy with no auvld -> ALU sees one op only, err=1.
//    auen coinciding with auvld -> forwarded, busy stays 1, err=0.
//  6 Async reset asserted mid-DRAIN, between clock edges
//    -> gnt, busy, err and all alu_*/ram_* go 0 immediately; late auvld is ignored.

Source files
------------

// File: rtl/auc_pkg.sv
// Shared constants for the ALU/RAM arbiter slice: default widths and FSM state encodings.
package auc_pkg;

    localparam int AUC_NREQ  = 3;
    localparam int AUC_WID   = 256;
    localparam int AUC_AWID  = 5;
    localparam int AUC_OPWID = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_GRANT = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/auc_rrpick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module auc_rrpick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          found
);

    int   pos_s;
    logic hit_s;

    // Walk the request vector starting at ptr and keep only the first hit
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        pos_s = 0;
        hit_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos_s      = (int'(ptr) + i >= N) ? int'(ptr) + i - N : int'(ptr) + i;
            hit_s      = ~found & req[pos_s];
            win[pos_s] = hit_s;
            idx        = hit_s ? IW'(pos_s) : idx;
            found      = found | hit_s;
        end
    end

endmodule

// File: rtl/auc_alu_arb.sv
// Session-locked round-robin arbiter that shares one modular ALU and the operand RAM
// port between NREQ sequencers; the owner keeps the port until it drops req and drains.
module auc_alu_arb
    import auc_pkg::*;
#(
    parameter int NREQ  = AUC_NREQ,
    parameter int WID   = AUC_WID,
    parameter int AWID  = AUC_AWID,
    parameter int OPWID = AUC_OPWID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*OPWID-1:0] req_opcode,
    input  logic [NREQ-1:0]       req_auen,
    input  logic [NREQ-1:0]       req_carry,
    input  logic [NREQ-1:0]       req_swapop,
    input  logic [NREQ-1:0]       req_swapvl,
    input  logic [NREQ*AWID-1:0]  req_ra,
    input  logic [NREQ*AWID-1:0]  req_wa,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*WID-1:0]   req_wd,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       req_auvld,
    output logic [OPWID-1:0]      alu_opcode,
    output logic                  alu_auen,
    output logic                  alu_carry,
    output logic                  alu_swapop,
    output logic                  alu_swapvl,
    input  logic                  alu_auvld,
    output logic [AWID-1:0]       ram_ra,
    output logic [AWID-1:0]       ram_wa,
    output logic                  ram_we,
    output logic [WID-1:0]        ram_wd,
    output logic                  busy,
    output logic                  err
);

    localparam int IW = $clog2(NREQ);

    state_t          state_r;
    logic [NREQ-1:0] gnt_r;
    logic [IW-1:0]   owner_r;
    logic [IW-1:0]   ptr_r;
    logic            busy_r;
    logic            err_r;

    logic [NREQ-1:0] win_s;
    logic [IW-1:0]   win_idx_s;
    logic            win_found_s;
    logic [IW-1:0]   ptr_nxt_s;
    logic            held_s;
    logic            granting_s;
    logic            own_auen_s;
    logic            own_we_s;
    logic            fwd_auen_s;
    logic            drop_auen_s;
    logic            stray_s;
    logic            busy_nxt_s;
    logic            err_nxt_s;

    auc_rrpick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rrpick (
        .req   (req),
        .ptr   (ptr_r),
        .win   (win_s),
        .idx   (win_idx_s),
        .found (win_found_s)
    );

    // Qualify the owner's strobes; a new op while one is outstanding is dropped and flagged
    always_comb begin
        held_s      = (state_r != ST_IDLE);
        granting_s  = (state_r == ST_GRANT);
        own_auen_s  = req_auen[owner_r];
        own_we_s    = req_we[owner_r];
        fwd_auen_s  = granting_s & own_auen_s & ~(busy_r & ~alu_auvld);
        drop_auen_s = granting_s & own_auen_s & busy_r & ~alu_auvld;
        stray_s     = |((req_auen | req_we) & ~gnt_r);
        busy_nxt_s  = fwd_auen_s | (busy_r & ~alu_auvld);
        err_nxt_s   = err_r | drop_auen_s | (alu_auvld & ~busy_r) | stray_s;
        ptr_nxt_s   = (win_idx_s == IW'(NREQ - 1)) ? '0 : win_idx_s + IW'(1);
    end

    // Route the owner's slice to the ALU/RAM; DRAIN keeps fields but blocks new strobes
    always_comb begin
        alu_opcode = '0;
        alu_auen   = 1'b0;
        alu_carry  = 1'b0;
        alu_swapop = 1'b0;
        alu_swapvl = 1'b0;
        ram_ra     = '0;
        ram_wa     = '0;
        ram_we     = 1'b0;
        ram_wd     = '0;
        if (held_s) begin
            alu_opcode = req_opcode[int'(owner_r)*OPWID +: OPWID];
            alu_carry  = req_carry[owner_r];
            alu_swapop = req_swapop[owner_r];
            alu_swapvl = req_swapvl[owner_r];
            ram_ra     = req_ra[int'(owner_r)*AWID +: AWID];
            ram_wa     = req_wa[int'(owner_r)*AWID +: AWID];
            ram_wd     = req_wd[int'(owner_r)*WID +: WID];
            alu_auen   = fwd_auen_s;
            ram_we     = granting_s & own_we_s;
        end else begin
            alu_auen   = 1'b0;
            ram_we     = 1'b0;
        end
    end

    // Session FSM, round-robin pointer and the busy/err status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            owner_r <= '0;
            ptr_r   <= '0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            err_r  <= err_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        state_r <= ST_GRANT;
                        gnt_r   <= win_s;
                        owner_r <= win_idx_s;
                        ptr_r   <= ptr_nxt_s;
                    end
                end
                ST_GRANT: begin
                    if (!req[owner_r]) begin
                        if (busy_nxt_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_IDLE;
                            gnt_r   <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (alu_auvld) begin
                        state_r <= ST_IDLE;
                        gnt_r   <= '0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign req_auvld = {NREQ{alu_auvld}} & gnt_r;

endmodule

// File: tb/tb_auc_alu_arb.sv
// Self-checking bench for auc_alu_arb: directed scenarios plus randomized traffic
// checked against a session-level reference model.
module tb_auc_alu_arb;

    localparam int NREQ  = 3;
    localparam int WID   = 256;
    localparam int AWID  = 5;
    localparam int OPWID = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req, req_auen, req_carry, req_swapop, req_swapvl, req_we;
    logic [NREQ*OPWID-1:0] req_opcode;
    logic [NREQ*AWID-1:0]  req_ra, req_wa;
    logic [NREQ*WID-1:0]   req_wd;
    logic [NREQ-1:0]       gnt, req_auvld;
    logic [OPWID-1:0]      alu_opcode;
    logic                  alu_auen, alu_carry, alu_swapop, alu_swapvl, alu_auvld;
    logic [AWID-1:0]       ram_ra, ram_wa;
    logic                  ram_we, busy, err;
    logic [WID-1:0]        ram_wd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    auc_alu_arb #(.NREQ(NREQ), .WID(WID), .AWID(AWID), .OPWID(OPWID)) dut (
        .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode), .req_auen(req_auen),
        .req_carry(req_carry), .req_swapop(req_swapop), .req_swapvl(req_swapvl),
        .req_ra(req_ra), .req_wa(req_wa), .req_we(req_we), .req_wd(req_wd),
        .gnt(gnt), .req_auvld(req_auvld), .alu_opcode(alu_opcode), .alu_auen(alu_auen),
        .alu_carry(alu_carry), .alu_swapop(alu_swapop), .alu_swapvl(alu_swapvl),
        .alu_auvld(alu_auvld), .ram_ra(ram_ra), .ram_wa(ram_wa), .ram_we(ram_we),
        .ram_wd(ram_wd), .busy(busy), .err(err)
    );

    // Reference model: who owns the port, whether it is draining, and one op in flight
    int  m_owner;
    int  m_ptr;
    bit  m_drain, m_busy, m_err;

    logic [NREQ-1:0]  e_gnt, e_auvld;
    logic [OPWID-1:0] e_opcode;
    logic             e_auen, e_carry, e_swapop, e_swapvl, e_we;
    logic [AWID-1:0]  e_ra, e_wa;
    logic [WID-1:0]   e_wd;

    always_comb begin
        e_gnt = '0; e_auvld = '0; e_opcode = '0; e_auen = 1'b0; e_carry = 1'b0;
        e_swapop = 1'b0; e_swapvl = 1'b0; e_ra = '0; e_wa = '0; e_we = 1'b0; e_wd = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner]   = 1'b1;
            e_auvld[m_owner] = alu_auvld;
            e_opcode = req_opcode[m_owner*OPWID +: OPWID];
            e_carry  = req_carry[m_owner];
            e_swapop = req_swapop[m_owner];
            e_swapvl = req_swapvl[m_owner];
            e_ra     = req_ra[m_owner*AWID +: AWID];
            e_wa     = req_wa[m_owner*AWID +: AWID];
            e_wd     = req_wd[m_owner*WID +: WID];
            e_auen   = !m_drain && req_auen[m_owner] && !(m_busy && !alu_auvld);
            e_we     = !m_drain && req_we[m_owner];
        end
    end

    always @(posedge clk or negedge rst) begin : mdl
        bit strays;
        bit dropped;
        bit nb;
        int w;
        if (!rst) begin
            m_owner <= -1; m_ptr <= 0; m_drain <= 1'b0; m_busy <= 1'b0; m_err <= 1'b0;
        end else begin
            strays = 1'b0;
            for (int j = 0; j < NREQ; j++)
                if ((req_auen[j] || req_we[j]) && j != m_owner) strays = 1'b1;
            dropped = 1'b0;
            if (m_owner >= 0)
                dropped = !m_drain && req_auen[m_owner] && m_busy && !alu_auvld;
            nb = e_auen || (m_busy && !alu_auvld);
            m_err  <= m_err || strays || dropped || (alu_auvld && !m_busy);
            m_busy <= nb;
            if (m_owner < 0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                if (w >= 0) begin
                    m_owner <= w;
                    m_ptr   <= (w + 1) % NREQ;
                end
            end else if (!m_drain) begin
                if (!req[m_owner]) begin
                    if (nb) m_drain <= 1'b1;
                    else    m_owner <= -1;
                end
            end else if (alu_auvld) begin
                m_owner <= -1;
                m_drain <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req = '0; req_auen = '0; req_carry = '0; req_swapop = '0; req_swapvl = '0;
        req_we = '0; req_opcode = '0; req_ra = '0; req_wa = '0; req_wd = '0;
        alu_auvld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, busy, err, alu_opcode, alu_auen, ram_we, ram_ra, req_auvld} !== '0) begin
            errors++;
            $display("FAIL reset: got gnt=%b busy=%b err=%b op=%h auen=%b we=%b, want all 0",
                     gnt, busy, err, alu_opcode, alu_auen, ram_we);
        end
    endtask

    task automatic test_single();
        int seen;
        do_reset();
        req = 3'b001;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL single_pre_gnt: got %b want 000", gnt); end
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b want 001", gnt); end
        req_opcode[3:0] = 4'h3;
        req_auen[0] = 1'b1;
        #1;
        checks++;
        if (alu_opcode !== 4'h3 || alu_auen !== 1'b1) begin
            errors++; $display("FAIL single_issue: got op=%h auen=%b want op=3 auen=1", alu_opcode, alu_auen);
        end
        tick();
        req_auen = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            alu_auvld = (c == 4);
            #1;
            if (req_auvld === 3'b001) seen++;
            tick();
        end
        alu_auvld = 1'b0;
        checks++; if (seen !== 1) begin errors++; $display("FAIL single_auvld_count: got %0d want 1", seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_clr: got %b want 0", busy); end
        req = '0;
        tick();
        checks++; if (gnt !== 3'b000 || err !== 1'b0) begin errors++; $display("FAIL single_release: got gnt=%b err=%b want 000/0", gnt, err); end
    endtask

    task automatic test_rr();
        int order[4] = '{0, 1, 2, 0};
        int waited;
        do_reset();
        req = 3'b111;
        for (int s = 0; s < 4; s++) begin
            waited = 0;
            while (gnt === 3'b000 && waited < 10) begin
                tick();
                waited++;
            end
            checks++;
            if (gnt !== 3'(1 << order[s]) || waited !== 1) begin
                errors++;
                $display("FAIL rr_session%0d: got gnt=%b idle=%0d want gnt=%b idle=1",
                         s, gnt, waited, 3'(1 << order[s]));
            end
            req_auen[order[s]] = 1'b1;
            tick();
            req_auen = '0;
            alu_auvld = 1'b1;
            tick();
            alu_auvld = 1'b0;
            req[order[s]] = 1'b0;
            tick();
            req[order[s]] = 1'b1;
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rr_err: got %b want 0", err); end
    endtask

    task automatic test_drain();
        do_reset();
        req = 3'b010;
        tick();
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL drain_gnt: got %b want 010", gnt); end
        req = 3'b100;
        req_auen[1] = 1'b1;
        req_opcode[7:4] = 4'h7;
        #1;
        checks++; if (alu_auen !== 1'b1) begin errors++; $display("FAIL drain_fwd: got %b want 1", alu_auen); end
        tick();
        req_auen = '0;
        for (int k = 1; k <= 8; k++) begin
            alu_auvld = (k == 8);
            #1;
            checks++;
            if (gnt !== 3'b010 || alu_opcode !== 4'h7) begin
                errors++; $display("FAIL drain_hold%0d: got gnt=%b op=%h want 010/7", k, gnt, alu_opcode);
            end
            tick();
        end
        alu_auvld = 1'b0;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL drain_gap: got %b want 000", gnt); end
        tick();
        checks++; if (gnt !== 3'b100 || err !== 1'b0) begin errors++; $display("FAIL drain_next: got gnt=%b err=%b want 100/0", gnt, err); end
    endtask

    task automatic test_mask();
        logic [WID-1:0] pat;
        pat = {8{32'h1234_5678}};
        do_reset();
        req = 3'b001;
        tick();
        req_we[0] = 1'b1; req_wa[4:0] = 5'd3; req_wd[WID-1:0] = pat;
        req_we[2] = 1'b1; req_wa[14:10] = 5'd9; req_wd[2*WID +: WID] = '1;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_wa !== 5'd3 || ram_wd !== pat) begin
            errors++; $display("FAIL mask_owner: got we=%b wa=%h wd=%h want 1/03/%h", ram_we, ram_wa, ram_wd, pat);
        end
        tick();
        req_we[0] = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mask_err: got %b want 1", err); end
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mask_block: got %b want 0", ram_we); end
        tick();
        req_we = '0;
        repeat (3) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mask_sticky: got %b want 1", err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 3'b001;
        tick();
        req_auen[0] = 1'b1;
        tick();
        #1;
        checks++; if (alu_auen !== 1'b0) begin errors++; $display("FAIL b2b_drop: got auen=%b want 0", alu_auen); end
        tick();
        req_auen = '0;
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_err: got err=%b busy=%b want 1/1", err, busy); end
        do_reset();
        req = 3'b001;
        tick();
        req_auen[0] = 1'b1;
        tick();
        alu_auvld = 1'b1;
        #1;
        checks++; if (alu_auen !== 1'b1) begin errors++; $display("FAIL b2b_overlap_fwd: got %b want 1", alu_auen); end
        tick();
        req_auen = '0; alu_auvld = 1'b0;
        checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL b2b_overlap: got busy=%b err=%b want 1/0", busy, err); end
        alu_auvld = 1'b1;
        tick();
        alu_auvld = 1'b0;
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL b2b_retire: got busy=%b err=%b want 0/0", busy, err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b010;
        tick();
        req_opcode[7:4] = 4'hA; req_ra[9:5] = 5'd17; req_wa[9:5] = 5'd21;
        req_carry[1] = 1'b1; req_swapop[1] = 1'b1; req_swapvl[1] = 1'b1;
        req_wd[WID +: WID] = {8{32'hDEAD_BEEF}};
        req_auen[1] = 1'b1;
        req = 3'b000;
        tick();
        req_auen = '0;
        tick();
        checks++;
        if (gnt !== 3'b010 || busy !== 1'b1 || ram_ra !== 5'd17) begin
            errors++; $display("FAIL areset_drain: got gnt=%b busy=%b ra=%h want 010/1/11", gnt, busy, ram_ra);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, err, alu_opcode, alu_auen, alu_carry, alu_swapop, alu_swapvl,
             ram_ra, ram_wa, ram_we} !== '0 || ram_wd !== '0) begin
            errors++; $display("FAIL areset_now: got gnt=%b busy=%b op=%h ra=%h wa=%h want all 0",
                               gnt, busy, alu_opcode, ram_ra, ram_wa);
        end
        alu_auvld = 1'b1;
        tick();
        checks++; if (req_auvld !== 3'b000 || err !== 1'b0 || gnt !== 3'b000) begin errors++; $display("FAIL areset_late_vld: got rv=%b err=%b gnt=%b want 000/0/000", req_auvld, err, gnt); end
        alu_auvld = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if ({gnt, busy, err} !== 5'b0) begin errors++; $display("FAIL areset_after: got gnt=%b busy=%b err=%b want 0", gnt, busy, err); end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < NREQ; j++) begin
                if ($urandom_range(7, 0) == 0) req[j] = ~req[j];
                req_opcode[j*OPWID +: OPWID] = OPWID'($urandom);
                req_ra[j*AWID +: AWID] = AWID'($urandom);
                req_wa[j*AWID +: AWID] = AWID'($urandom);
                req_carry[j] = 1'($urandom); req_swapop[j] = 1'($urandom); req_swapvl[j] = 1'($urandom);
                for (int q = 0; q < WID / 32; q++) req_wd[j*WID + q*32 +: 32] = $urandom;
                if (j == m_owner) begin
                    req_auen[j] = ($urandom_range(3, 0) == 0);
                    req_we[j]   = ($urandom_range(2, 0) == 0);
                end else begin
                    req_auen[j] = ($urandom_range(99, 0) == 0);
                    req_we[j]   = ($urandom_range(99, 0) == 0);
                end
            end
            alu_auvld = m_busy ? ($urandom_range(2, 0) == 0) : ($urandom_range(99, 0) == 0);
            #1;
            checks++;
            if ({gnt, busy, err, req_auvld, alu_opcode, alu_auen, alu_carry, alu_swapop, alu_swapvl,
                 ram_ra, ram_wa, ram_we} !==
                {e_gnt, m_busy, m_err, e_auvld, e_opcode, e_auen, e_carry, e_swapop, e_swapvl,
                 e_ra, e_wa, e_we} || ram_wd !== e_wd) begin
                errors++;
                $display("FAIL random_c%0d: got gnt=%b busy=%b err=%b rv=%b op=%h auen=%b we=%b ra=%h wa=%h, want gnt=%b busy=%b err=%b rv=%b op=%h auen=%b we=%b ra=%h wa=%h",
                         c, gnt, busy, err, req_auvld, alu_opcode, alu_auen, ram_we, ram_ra, ram_wa,
                         e_gnt, m_busy, m_err, e_auvld, e_opcode, e_auen, e_we, e_ra, e_wa);
            end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_rr();
        test_drain();
        test_mask();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
